// File: rtl/audio_pdm_tx_if.sv
// Sample handshake and PDM output bundle for audio_pdm_tx.
// The master side is the sample producer and PDM sink; the slave side is the transmitter.
interface audio_pdm_tx_if #(
  parameter int DEPTH = 16
) ();
  logic                     enable_in;
  logic [7:0]               sample_in;
  logic                     sample_valid_in;
  logic                     sample_ready_out;
  logic                     pdm_out;
  logic                     pdm_clk_out;
  logic                     underrun_out;
  logic [$clog2(DEPTH):0]   fifo_count_out;

  modport master (
    output enable_in, sample_in, sample_valid_in,
    input  sample_ready_out, pdm_out, pdm_clk_out, underrun_out, fifo_count_out
  );

  modport slave (
    input  enable_in, sample_in, sample_valid_in,
    output sample_ready_out, pdm_out, pdm_clk_out, underrun_out, fifo_count_out
  );
endinterface

// File: rtl/audio_pdm_tx.sv
// First-order sigma-delta PDM transmitter fed by a sample FIFO; one sample per NUM_PDM_SAMPLES bit ticks.
// Sample emitted at the next period start; ready drops only when the FIFO is full.
module audio_pdm_tx #(
  parameter int PDM_COUNT_PERIOD = 32,
  parameter int NUM_PDM_SAMPLES  = 256,
  parameter int DEPTH            = 16
) (
  input logic           clk_in,
  input logic           rst_in,
  audio_pdm_tx_if.slave bus
);
  localparam int CW = $clog2(PDM_COUNT_PERIOD);
  localparam int TW = $clog2(NUM_PDM_SAMPLES);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] C_LAST = CW'(PDM_COUNT_PERIOD - 1);
  localparam logic [CW-1:0] C_TICK = CW'(PDM_COUNT_PERIOD / 2 - 1);
  localparam logic [CW-1:0] C_HALF = CW'(PDM_COUNT_PERIOD / 2);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] c;
  logic [CW-1:0] c_next;
  logic [TW-1:0] t;
  logic [7:0]    acc;
  logic [7:0]    cur;
  logic [7:0]    s_eff;
  logic [8:0]    acc_next;
  logic          pdm;
  logic          pdm_clk;
  logic          underrun;
  logic          ready;
  logic          empty;
  logic          push;
  logic          pop;
  logic          tick;
  logic          frame;

  // Ready comes from the registered count only, so a full FIFO refuses a push even while popping.
  assign ready = count < (AW + 1)'(DEPTH);
  assign empty = (count == '0);
  assign push  = bus.sample_valid_in && ready;
  assign tick  = bus.enable_in && (c == C_TICK);
  assign frame = tick && (t == '0);
  assign pop   = frame && !empty;

  always_comb begin
    c_next = '0;
    if (bus.enable_in) begin
      c_next = (c == C_LAST) ? '0 : c + 1'b1;
    end
  end

  // The head popped at a period start drives the modulator on that same tick.
  always_comb begin
    s_eff = cur;
    if (frame) begin
      s_eff = empty ? 8'h00 : mem[rd_ptr];
    end
  end

  assign acc_next = {1'b0, acc} + {1'b0, ~s_eff[7], s_eff[6:0]};

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= bus.sample_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Dropping enable abandons the period outright; the popped sample is not restored.
  always_ff @(posedge clk_in) begin
    if (rst_in || !bus.enable_in) begin
      c        <= '0;
      t        <= '0;
      acc      <= '0;
      cur      <= '0;
      pdm      <= 1'b0;
      pdm_clk  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      c        <= c_next;
      pdm_clk  <= (c_next < C_HALF);
      underrun <= frame && empty;
      if (tick) begin
        t   <= t + 1'b1;
        acc <= acc_next[7:0];
        pdm <= acc_next[8];
      end
      if (frame) begin
        cur <= s_eff;
      end
    end
  end

  assign bus.sample_ready_out = ready;
  assign bus.pdm_out          = pdm;
  assign bus.pdm_clk_out      = pdm_clk;
  assign bus.underrun_out     = underrun;
  assign bus.fifo_count_out   = count;
endmodule

// File: tb/tb_audio_pdm_tx.sv
// Scoreboard bench for audio_pdm_tx: expected per-period ones counts queued on push, compared per period.
module tb_audio_pdm_tx;
  localparam int P = 8;
  localparam int N = 256;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  audio_pdm_tx_if #(.DEPTH(D)) bus ();

  audio_pdm_tx #(
    .PDM_COUNT_PERIOD(P),
    .NUM_PDM_SAMPLES (N),
    .DEPTH           (D)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  int           total = 0;
  int           bad   = 0;
  int           sb[$];
  logic [N-1:0] bits;
  int           ones;
  int           ur_cnt;
  int           clk_per;
  int           clk_high;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int out_vec();
    return int'({bus.pdm_out, bus.pdm_clk_out, bus.underrun_out, bus.sample_ready_out, bus.fifo_count_out});
  endfunction

  // Count n PDM bits, sampled where pdm_clk_out falls (the edge on which pdm_out updates).
  task automatic run_ticks(input int n);
    int   falls = 0;
    int   cyc = 0;
    int   last_rise = -1;
    logic prev;
    ones   = 0;
    ur_cnt = 0;
    bits   = '0;
    prev   = bus.pdm_clk_out;
    while (falls < n && cyc <= n * P + 4 * P) begin
      @(negedge clk);
      cyc++;
      if (bus.underrun_out) ur_cnt++;
      if (!prev && bus.pdm_clk_out) begin
        if (last_rise >= 0) clk_per = cyc - last_rise;
        last_rise = cyc;
      end
      if (prev && !bus.pdm_clk_out) begin
        bits[falls] = bus.pdm_out;
        ones += int'(bus.pdm_out);
        falls++;
        if (last_rise >= 0) clk_high = cyc - last_rise;
      end
      prev = bus.pdm_clk_out;
    end
    if (falls < n) chk("tick_timeout", falls, n);
  endtask

  task automatic check_period(input string tag);
    int exp_ones;
    int exp_ur;
    exp_ur   = (sb.size() == 0) ? 1 : 0;
    exp_ones = (exp_ur == 1) ? N / 2 : sb.pop_front();
    run_ticks(N);
    chk({tag, "_ones"}, ones, exp_ones);
    chk({tag, "_ur"}, ur_cnt, exp_ur);
  endtask

  task automatic push_sample(input logic [7:0] s);
    int w = 0;
    bus.sample_in       = s;
    bus.sample_valid_in = 1'b1;
    while (!bus.sample_ready_out && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) chk("push_timeout", 0, 1);
    else sb.push_back(int'($signed(s)) + 128);
    @(negedge clk);
    bus.sample_valid_in = 1'b0;
  endtask

  initial begin
    int idle_exp;
    idle_exp = int'({1'b0, 1'b0, 1'b0, 1'b1, 5'd0});
    bus.enable_in       = 1'b0;
    bus.sample_in       = 8'h00;
    bus.sample_valid_in = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("reset_state", out_vec(), idle_exp);
    end
    rst = 1'b0;
    repeat (100) begin
      @(negedge clk);
      chk("idle", out_vec(), idle_exp);
    end

    // Midscale density and bit clock shape
    push_sample(8'h00);
    chk("cnt_one", int'(bus.fifo_count_out), 1);
    bus.enable_in = 1'b1;
    check_period("d00");
    chk("d00_pat_lo", int'(bits[31:0]), int'(32'hAAAA_AAAA));
    chk("d00_pat_all", int'(bits == {128{2'b10}}), 1);
    chk("clk_period", clk_per, P);
    chk("clk_high", clk_high, P / 2);
    bus.enable_in = 1'b0;
    @(negedge clk);

    // Extremes and midpoint
    push_sample(8'h7F);
    push_sample(8'h80);
    push_sample(8'h40);
    bus.enable_in = 1'b1;
    check_period("x7f");
    check_period("x80");
    check_period("x40");
    bus.enable_in = 1'b0;
    @(negedge clk);

    // Underrun, then a sample arriving mid-period
    bus.enable_in = 1'b1;
    fork
      check_period("ur_first");
      begin
        repeat (N * P / 2) @(negedge clk);
        push_sample(8'h7F);
      end
    join
    check_period("ur_next");
    bus.enable_in = 1'b0;
    @(negedge clk);

    // Backpressure with valid held across a full FIFO
    for (int i = 1; i <= 20; i++) begin
      bus.sample_in       = 8'(i);
      bus.sample_valid_in = 1'b1;
      chk($sformatf("bp_rdy%0d", i), int'(bus.sample_ready_out), (i <= D) ? 1 : 0);
      if (i <= D) sb.push_back(i + 128);
      @(negedge clk);
    end
    bus.sample_valid_in = 1'b0;
    chk("bp_cnt", int'(bus.fifo_count_out), D);
    chk("bp_rdy_full", int'(bus.sample_ready_out), 0);
    bus.enable_in = 1'b1;
    for (int k = 0; k < D; k++) check_period($sformatf("bp%0d", k));
    bus.enable_in = 1'b0;
    @(negedge clk);
    chk("bp_drained", int'(bus.fifo_count_out), 0);

    // Abort by dropping enable at t=100
    push_sample(8'd10);
    push_sample(8'd20);
    push_sample(8'd30);
    bus.enable_in = 1'b1;
    void'(sb.pop_front());
    run_ticks(100);
    bus.enable_in = 1'b0;
    @(negedge clk);
    chk("ab_en_pdm", int'(bus.pdm_out), 0);
    chk("ab_en_pclk", int'(bus.pdm_clk_out), 0);
    chk("ab_en_cnt", int'(bus.fifo_count_out), 2);
    bus.enable_in = 1'b1;
    check_period("ab_en_next");
    bus.enable_in = 1'b0;
    @(negedge clk);

    // Abort by reset mid-period; the next enable starts with an underrun
    bus.enable_in = 1'b1;
    void'(sb.pop_front());
    run_ticks(100);
    rst = 1'b1;
    @(negedge clk);
    chk("ab_rst_vec", out_vec(), idle_exp);
    sb.delete();
    rst = 1'b0;
    check_period("ab_rst_ur");
    bus.enable_in = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/audio_pdm_tx.md
Name: audio_pdm_tx

Overview:
- 1-bit PDM transmitter for audio playback. It is the output-direction counterpart of the microphone PDM decimator.
- Accepts 8-bit signed samples (recorder/playback path, ~12 kHz) through a valid/ready handshake into a small FIFO.
- Emits one sample per NUM_PDM_SAMPLES PDM ticks as a first-order sigma-delta bitstream, plus a companion PDM clock.
- Runs in the 98.3 MHz audio clock domain (clk_m in the top level).

Parameters:
- PDM_COUNT_PERIOD, 32: system cycles per PDM bit; even, ≥4 (98.3 MHz / 32 ≈ 3.072 MHz).
- NUM_PDM_SAMPLES, 256: PDM bits per audio sample; power of 2.
- DEPTH, 16: sample FIFO depth; power of 2, ≥2.

Ports:
- clk_in  input  1  system clock (audio clock domain).
- rst_in  input  1  synchronous, active-high reset.
- enable_in  input  1  run modulator; low = idle, FIFO retained.
- sample_in  input  8  signed audio sample.
- sample_valid_in  input  1  sample_in valid this cycle.
- sample_ready_out  output  1  FIFO can accept; equals (count < DEPTH).
- pdm_out  output  1  registered PDM data bit.
- pdm_clk_out  output  1  registered PDM clock, 50% duty.
- underrun_out  output  1  one-cycle pulse: sample period started with FIFO empty.
- fifo_count_out  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_in=1, dominates everything):
  - Counters, FIFO pointers and count cleared; accumulator = 0; current sample = 0.
  - pdm_out=0, pdm_clk_out=0, underrun_out=0, fifo_count_out=0, sample_ready_out=1 from the first cycle after reset.
- FIFO:
  - Push when sample_valid_in && sample_ready_out. A valid without ready is dropped; the producer must hold the sample.
  - Ready derives from registered count only: when full, no push is accepted even if a pop occurs in the same cycle.
  - Simultaneous push and pop: count unchanged.
  - No bypass: a push into an empty FIFO is not visible to a pop in the same cycle.
  - Pointers wrap modulo DEPTH.
- Bit clock:
  - Counter c runs 0..PDM_COUNT_PERIOD-1 and wraps.
  - pdm_clk_out <= (c_next < PDM_COUNT_PERIOD/2).
  - A tick occurs on a cycle with enable_in=1 and c == PDM_COUNT_PERIOD/2-1.
  - pdm_out updates on the edge where pdm_clk_out falls, so the sink samples stable data on the rising edge.
- Sample framing:
  - Tick counter t runs 0..NUM_PDM_SAMPLES-1 and advances once per tick.
  - On the tick with t==0:
    - FIFO non-empty: pop the head; it becomes the current sample and is the modulator input on this same tick.
    - FIFO empty: current sample = 0 (midscale) and underrun_out=1 for that cycle.
  - The current sample is held for the remaining ticks of the period.
- Modulator, on each tick:
  - u = {~s[7], s[6:0]} (unsigned offset binary, 0..255).
  - acc_next = {1'b0, acc[7:0]} + u, 9 bits; pdm_out <= acc_next[8]; acc <= acc_next[7:0].
  - Ones per sample period = u exactly, from the period-aligned accumulator state defined below.
- enable_in low:
  - c, t, acc and current sample are forced to 0; pdm_out=0, pdm_clk_out=0; no ticks, no pops, no underrun pulses.
  - FIFO push still allowed.
  - Dropping enable mid-period abandons that period; the popped sample is not restored.
- On enable_in rising:
  - The first tick occurs PDM_COUNT_PERIOD/2 cycles later (c counts from 0).
  - That tick has t==0 and pops.
- Latency: a sample pushed into an empty FIFO while enabled is emitted at the next t==0 tick, within NUM_PDM_SAMPLES·PDM_COUNT_PERIOD cycles.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst_in 3 cycles; enable_in=0 for 100 cycles.
  - Required: pdm_out=0, pdm_clk_out=0, underrun_out=0, fifo_count_out=0, sample_ready_out=1 throughout.
- Density, sample 8'h00:
  - Stimulus: push 8'h00, enable_in=1.
  - Required: first period gives exactly 128 ones in 256 ticks, pattern 0,1,0,1…; pdm_clk_out period 32 cycles, high 16.
- Extremes and midpoint:
  - Stimulus: push 8'h7F, 8'h80, 8'h40.
  - Required: consecutive periods give 255, 0 and 192 ones respectively.
- Underrun:
  - Stimulus: enable with FIFO empty, then push 8'h7F mid-period.
  - Required: underrun_out pulses once at the first t==0 tick and that period has 128 ones; next period has 255 ones with no pulse.
- Backpressure:
  - Stimulus: enable_in=0, push 20 samples 1..20 with valid held.
  - Required: sample_ready_out falls after 16 accepts; fifo_count_out=16; enabling emits samples 1..16 in order (densities u = s+128).
- Mid-operation abort:
  - Stimulus: drop enable_in at t=100 of a period, or assert rst_in mid-period.
  - Required: pdm_out=0 next cycle.
    - Enable case: FIFO count preserved minus the popped sample.
    - Reset case: count=0, and the next enable starts with underrun.
